// File: rtl/orb_pkg.sv
// Shared definitions for the multi-channel orbital word packer:
// default widths plus the word-format and RAM-address helpers.
package orb_pkg;

    localparam int DW_DEF    = 8;
    localparam int OW_DEF    = 12;
    localparam int AW_DEF    = 11;
    localparam int WORDS_DEF = 16;
    localparam int NCH_DEF   = 5;

    // Orbital word layout: {1'b0, data, (ow-1-dw) zeros}. The result is
    // returned 32 bits wide; callers keep the low ow bits.
    function automatic logic [31:0] fmt_word(input logic [31:0] data,
                                             input int dw = DW_DEF,
                                             input int ow = OW_DEF);
        logic [31:0] mask;
        mask = (32'd1 << dw) - 32'd1;
        return (data & mask) << (ow - 1 - dw);
    endfunction

    // Frame layout: packs are contiguous, and within a pack the channels
    // are interleaved word by word.
    function automatic logic [31:0] orb_addr(input int pack,
                                             input int word,
                                             input int ch,
                                             input int words = WORDS_DEF,
                                             input int nch   = NCH_DEF);
        return 32'(pack * words * nch + word * nch + ch);
    endfunction

endpackage

// File: rtl/orb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found by searching
// upward from the rr pointer, wrapping modulo N.
module orb_rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Rotating priority search; the first hit wins and later hits are ignored.
    always_comb begin
        int j;
        j     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr) + k;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                idx    = IW'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/orb_packer_mc.sv
// Multi-channel orbital word packer. Each channel samples its byte on a
// strobe edge, waits a programmable delay, then competes for the single
// frame-RAM write port through a round-robin arbiter. An SW toggle
// restarts the frame layout for all channels.
module orb_packer_mc
    import orb_pkg::*;
#(
    parameter int NCH      = 5,
    parameter int DW       = 8,
    parameter int OW       = 12,
    parameter int AW       = 11,
    parameter int WORDS    = 16,
    parameter int SKIP     = 2,
    parameter int PACKS    = 16,
    parameter int WE_DELAY = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] iData,
    input  logic [NCH-1:0]    strob,
    input  logic              SW,
    output logic [OW-1:0]     orbWord,
    output logic [AW-1:0]     WrAddr,
    output logic              WE,
    output logic              test,
    output logic [NCH-1:0]    ovf
);

    localparam int CW  = (WORDS + SKIP > 1) ? $clog2(WORDS + SKIP) : 1;
    localparam int PW  = (PACKS > 1) ? $clog2(PACKS) : 1;
    localparam int DLW = $clog2(WE_DELAY + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] strob_s1, strob_s2, strob_prev, stb_edge;
    logic           sw_s1, sw_s2, sw_old, restart;
    logic [NCH-1:0] pend, ready, gnt;
    logic [DW-1:0]  data_q [NCH];
    logic [AW-1:0]  addr_q [NCH];
    logic [IW-1:0]  rr, gnt_idx;
    logic           gnt_vld, grant;
    logic [31:0]    word_full;

    // Two-flop synchronisers for the asynchronous strobes and SW, plus the
    // one-cycle history used for edge/toggle detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strob_s1   <= '0;
            strob_s2   <= '0;
            strob_prev <= '0;
            sw_s1      <= 1'b0;
            sw_s2      <= 1'b0;
            sw_old     <= 1'b0;
        end else begin
            strob_s1   <= strob;
            strob_s2   <= strob_s1;
            strob_prev <= strob_s2;
            sw_s1      <= SW;
            sw_s2      <= sw_s1;
            sw_old     <= sw_s2;
        end
    end

    assign stb_edge = strob_s2 & ~strob_prev;
    assign restart  = sw_s2 ^ sw_old;
    // No grant is made while the frame is restarting.
    assign grant    = gnt_vld & ~restart;

    orb_rr_arbiter #(.N(NCH), .IW(IW)) u_arb (
        .req   (ready),
        .rr    (rr),
        .gnt   (gnt),
        .idx   (gnt_idx),
        .valid (gnt_vld)
    );

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CW-1:0]  cnt_wrd;
        logic [PW-1:0]  cnt_pack;
        logic [DLW-1:0] dly;
        logic           pend_c, ovf_c, store, granted_c;
        logic [DW-1:0]  data_c;
        logic [AW-1:0]  addr_c;
        logic [31:0]    addr_full;

        assign store     = stb_edge[c] && (32'(cnt_wrd) < 32'(WORDS));
        assign granted_c = grant && gnt[c];
        assign addr_full = orb_addr(int'(cnt_pack), int'(cnt_wrd), c, WORDS, NCH);
        assign ready[c]  = pend_c && (dly == '0);
        assign pend[c]   = pend_c;
        assign ovf[c]    = ovf_c;
        assign data_q[c] = data_c;
        assign addr_q[c] = addr_c;

        // Slot counters, pending flag, write delay and sticky overflow.
        // A grant in the same cycle as a new store frees the old word, so
        // that case is not an overflow.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_wrd  <= '0;
                cnt_pack <= '0;
                pend_c   <= 1'b0;
                dly      <= '0;
                ovf_c    <= 1'b0;
            end else if (restart) begin
                cnt_wrd  <= '0;
                cnt_pack <= '0;
                pend_c   <= 1'b0;
                dly      <= '0;
                ovf_c    <= 1'b0;
            end else begin
                if (stb_edge[c]) begin
                    if (32'(cnt_wrd) == WORDS + SKIP - 1) begin
                        cnt_wrd  <= '0;
                        cnt_pack <= (32'(cnt_pack) == PACKS - 1) ? '0 : cnt_pack + 1'b1;
                    end else begin
                        cnt_wrd  <= cnt_wrd + 1'b1;
                    end
                end
                if (store) begin
                    pend_c <= 1'b1;
                    dly    <= DLW'(WE_DELAY - 1);
                    if (pend_c && !granted_c) ovf_c <= 1'b1;
                end else if (granted_c) begin
                    pend_c <= 1'b0;
                end else if (pend_c && dly != '0) begin
                    dly    <= dly - 1'b1;
                end
            end
        end

        // Byte and address capture on a store edge; data path needs no reset.
        always_ff @(posedge clk) begin
            if (store && !restart) begin
                data_c <= iData[c*DW +: DW];
                addr_c <= addr_full[AW-1:0];
            end
        end
    end

    assign word_full = fmt_word(32'(data_q[gnt_idx]), DW, OW);

    // Registered write port, test pulse and round-robin pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE      <= 1'b0;
            orbWord <= '0;
            WrAddr  <= '0;
            test    <= 1'b0;
            rr      <= '0;
        end else begin
            test <= restart;
            WE   <= grant;
            if (restart) begin
                rr <= '0;
            end else if (grant) begin
                orbWord <= word_full[OW-1:0];
                WrAddr  <= addr_q[gnt_idx];
                rr      <= (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_orb_packer_mc.sv
// Scoreboard bench for orb_packer_mc: stimulus pushes expected writes,
// a negedge monitor pops and compares on every WE.
module tb_orb_packer_mc;

    localparam int NCH = 5, DW = 8, OW = 12, AW = 11;
    localparam int WORDS = 16, SKIP = 2, PACKS = 16, WE_DELAY = 28;
    localparam int SLOTS = WORDS + SKIP;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH*DW-1:0] iData = '0;
    logic [NCH-1:0]    strob = '0;
    logic              SW = 1'b0;
    logic [OW-1:0]     orbWord;
    logic [AW-1:0]     WrAddr;
    logic              WE, test;
    logic [NCH-1:0]    ovf;

    orb_packer_mc #(
        .NCH(NCH), .DW(DW), .OW(OW), .AW(AW), .WORDS(WORDS),
        .SKIP(SKIP), .PACKS(PACKS), .WE_DELAY(WE_DELAY)
    ) dut (
        .clk(clk), .rst(rst), .iData(iData), .strob(strob), .SW(SW),
        .orbWord(orbWord), .WrAddr(WrAddr), .WE(WE), .test(test), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [OW-1:0] word;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   we_run = 0;
    int   best_run = 0;

    // Word format {0, byte, 000} for the 12-bit word / 8-bit byte case.
    function automatic logic [OW-1:0] w_of(input logic [7:0] b);
        return {1'b0, b, 3'b000};
    endfunction

    // Frame address: 80 words per pack, channels interleaved.
    function automatic logic [AW-1:0] a_of(input int p, input int w, input int c);
        return AW'(p * WORDS * NCH + w * NCH + c);
    endfunction

    task automatic push(input int p, input int w, input int c, input logic [7:0] b);
        exp_t e;
        e.addr = a_of(p, w, c);
        e.word = w_of(b);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic set_byte(input int c, input logic [7:0] b);
        iData[c*DW +: DW] = b;
    endtask

    task automatic strobe_mask(input logic [NCH-1:0] m);
        strob = m;
        repeat (4) @(negedge clk);
        strob = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic strobe_wait(input int c, input logic [7:0] b);
        logic [NCH-1:0] m;
        m = '0;
        m[c] = 1'b1;
        set_byte(c, b);
        strobe_mask(m);
        repeat (WE_DELAY + 6) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d writes outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        strob = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Monitor: every WE must match the oldest expected write.
    always @(negedge clk) begin
        if (WE) begin
            we_run++;
            if (we_run > best_run) best_run = we_run;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_we: got addr=%0d word=%h, required no write", WrAddr, orbWord);
            end else begin
                mon_e = sb.pop_front();
                if (WrAddr !== mon_e.addr || orbWord !== mon_e.word) begin
                    fails++;
                    $display("FAIL we_word: got addr=%0d word=%h, required addr=%0d word=%h",
                             WrAddr, orbWord, mon_e.addr, mon_e.word);
                end
            end
        end else begin
            we_run = 0;
        end
    end

    initial begin
        int lat;
        int cnt;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(WE), 0);
        chk("rst_word", 32'(orbWord), 0);
        chk("rst_addr", 32'(WrAddr), 0);
        chk("rst_test", 32'(test), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Single channel, latency window
        set_byte(0, 8'hA5);
        push(0, 0, 0, 8'hA5);
        strob[0] = 1'b1;
        lat = 0;
        while (!WE && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 4) strob[0] = 1'b0;
        end
        strob = '0;
        tests++;
        if (lat < WE_DELAY + 1 || lat > WE_DELAY + 3) begin
            fails++;
            $display("FAIL single_latency: got %0d cycles, required %0d..%0d",
                     lat, WE_DELAY + 1, WE_DELAY + 3);
        end
        repeat (40) @(negedge clk);
        drain(1);

        // Frame layout on channel 2
        do_reset();
        for (int i = 0; i < SLOTS; i++) begin
            b = 8'(i);
            if (i < WORDS) push(0, i, 2, b);
            strobe_wait(2, b);
        end
        push(1, 0, 2, 8'd18);
        strobe_wait(2, 8'd18);
        drain(20);

        // Contention from rr = 0
        do_reset();
        best_run = 0;
        for (int c = 0; c < NCH; c++) begin
            set_byte(c, 8'(8'h10 + c));
            push(0, 0, c, 8'(8'h10 + c));
        end
        strobe_mask('1);
        drain(60);
        chk("contention_burst", 32'(best_run), 5);

        // Contention from rr = 3 (one write on channel 2 first)
        do_reset();
        push(0, 0, 2, 8'h77);
        strobe_wait(2, 8'h77);
        drain(20);
        for (int c = 0; c < NCH; c++) set_byte(c, 8'(8'h20 + c));
        push(0, 0, 3, 8'h23);
        push(0, 0, 4, 8'h24);
        push(0, 0, 0, 8'h20);
        push(0, 0, 1, 8'h21);
        push(0, 1, 2, 8'h22);
        strobe_mask('1);
        drain(60);

        // Overflow on channel 1
        do_reset();
        set_byte(1, 8'h11);
        strob = 5'b00010;
        repeat (5) @(negedge clk);
        strob = '0;
        repeat (5) @(negedge clk);
        set_byte(1, 8'h22);
        strob = 5'b00010;
        repeat (5) @(negedge clk);
        strob = '0;
        push(0, 1, 1, 8'h22);
        repeat (3) @(negedge clk);
        chk("ovf_set", 32'(ovf), 32'h02);
        drain(60);
        repeat (40) @(negedge clk);
        chk("ovf_sticky", 32'(ovf), 32'h02);

        // Restart with pending words
        do_reset();
        set_byte(1, 8'h11);
        set_byte(3, 8'h33);
        strob = 5'b01010;
        repeat (5) @(negedge clk);
        strob = '0;
        repeat (5) @(negedge clk);
        set_byte(1, 8'h12);
        strob = 5'b00010;
        repeat (5) @(negedge clk);
        strob = '0;
        repeat (2) @(negedge clk);
        chk("ovf_before_restart", 32'(ovf), 32'h02);
        SW = ~SW;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (test) cnt++;
        end
        chk("test_pulse", 32'(cnt), 1);
        chk("ovf_cleared", 32'(ovf), 0);
        repeat (50) @(negedge clk);
        push(0, 0, 3, 8'h5A);
        strobe_wait(3, 8'h5A);
        drain(20);

        // Full-frame wrap on channel 0
        do_reset();
        for (int i = 0; i < PACKS * SLOTS; i++) begin
            b = 8'(i);
            if ((i % SLOTS) < WORDS) push(i / SLOTS, i % SLOTS, 0, b);
            strobe_wait(0, b);
        end
        push(0, 0, 0, 8'hEE);
        strobe_wait(0, 8'hEE);
        drain(20);

        // Reset while a word is pending
        set_byte(4, 8'h44);
        strobe_mask(5'b10000);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_we", 32'(WE), 0);
        chk("midrst_word", 32'(orbWord), 0);
        chk("midrst_addr", 32'(WrAddr), 0);
        chk("midrst_ovf", 32'(ovf), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/orb_packer_mc.md
Name: orb_packer_mc

Overview:
- Parametrised multi-channel successor to the two-channel orbital word packer.
- Collects bytes from NCH strobed serial-receiver channels, formats each into an OW-bit orbital word and writes it into a shared frame RAM through one write port.
- Shared-port access uses a round-robin arbiter. Each channel has a programmable write delay, overflow detection and a synchronous frame restart on SW toggle.
- Sits between the channel receivers and the dual-port telemetry frame RAM.

Parameters:
- NCH, 5, number of input channels
- DW, 8, data byte width
- OW, 12, orbital word width; requires OW >= DW+1
- AW, 11, RAM address width
- WORDS, 16, words stored per channel per pack
- SKIP, 2, trailing strobes per pack that are counted but not stored
- PACKS, 16, packs per frame; requires PACKS*WORDS*NCH <= 2**AW
- WE_DELAY, 28, cycles from strobe edge to write request

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- iData  in  NCH*DW  channel c occupies bits [c*DW +: DW]
- strob  in  NCH  per-channel data strobe, asynchronous to clk
- SW  in  1  frame-switch input, asynchronous
- orbWord  out  OW  word to RAM
- WrAddr  out  AW  RAM write address
- WE  out  1  one-cycle write enable
- test  out  1  one-cycle pulse on each detected SW toggle
- ovf  out  NCH  sticky per-channel overflow flags

Behaviour:
- Reset and clocking: one clock (clk); reset asynchronous, active-high (rst). On reset all outputs are 0, as are all counters, pending flags and the rr pointer.
- Synchronisers: strob[c] and SW each pass through a 2-FF synchroniser.
- Edge detection: strobe rising edge is sync[1] & ~prev. SW toggle is sync[1] != oldSW.
- Per-channel counters: cntWrd range 0..WORDS+SKIP-1; cntPack width clog2(PACKS), wraps to 0.
- Strobe edge, store case: if cntWrd < WORDS:
  - capture iData[c] in the same cycle;
  - latch addr = cntPack*WORDS*NCH + cntWrd*NCH + c, truncated to AW;
  - set pend[c] and load dly[c] = WE_DELAY-1.
- Strobe edge, other cases:
  - cntWrd == WORDS+SKIP-1: cntWrd <= 0 and cntPack++.
  - Otherwise cntWrd++.
- Delay: dly[c] counts down while pend[c]. At 0 the channel is ready.
- Arbiter:
  - Each cycle, grant the first ready channel searching from rr upward, wrapping modulo NCH.
  - Registered outputs next cycle: WE=1, orbWord={1'b0, data, (OW-1-DW) zeros}, WrAddr=addr.
  - Clear pend for the granted channel; rr <= granted+1 mod NCH.
  - WE=0 when nothing is granted; orbWord and WrAddr hold their last values.
- Latency: at least WE_DELAY+1 cycles from edge to WE (arbiter adds 0..NCH-1 cycles). Worst case WE_DELAY+NCH.
- Overflow: a store-edge while pend[c] is still set overwrites data, addr and dly and sets ovf[c] (sticky). Only one write is issued, for the new word. Ovf is not set by skip-slot edges.
- Simultaneous grant and new edge on the same channel: the grant uses the old contents. The new word becomes pending and ovf is not set.
- Restart on SW toggle, in the same cycle:
  - clear all cntWrd, cntPack, pend, dly and ovf; rr <= 0;
  - test=1 for exactly one cycle.
  - Strobe edges in that cycle are discarded.
  - A write already registered on the outputs in that cycle completes. No grant is made in the restart cycle.
- Reset mid-operation: asynchronous clear. Pending words are lost and no WE is emitted.

Decomposition:
- Shared package orb_pkg: OW/DW/AW defaults, word-format function fmt_word(data), address function orb_addr(pack, word, ch).
- Sub-module orb_rr_arbiter (parameter N): inputs req[N] and rr pointer; outputs grant one-hot, grant index, valid.
- Per-channel logic is a generate loop in the top module.

Test Plan:
- Single channel: strob[0] edge with iData[7:0]=0xA5 at pack 0, word 0 -> after WE_DELAY+1..+3 cycles one WE pulse, orbWord=0x528, WrAddr=0; no other WE.
- Frame layout: 18 strobes on channel 2, bytes 0..17 -> 16 writes at WrAddr 2,7,12,...,77; strobes 17 and 18 produce no WE. Next strobe writes WrAddr 82 (pack 1).
- Contention: all 5 channels strobe in the same cycle -> 5 consecutive WE cycles, addresses 0,1,2,3,4 in round-robin order. Repeat with rr at 3: order 3,4,0,1,2.
- Overflow: two store-edges on channel 1 spaced 10 cycles apart -> ovf[1]=1; exactly one WE, carrying the second byte and the word-1 address (6).
- Restart: SW toggles mid-pack, with a channel pending -> test high for 1 cycle, ovf cleared, the pending word is never written. Next strobe writes WrAddr=c (pack 0, word 0).
- Wrap and reset: drive PACKS*18 strobes -> the address returns to pack 0. Assert rst during a pending delay -> all outputs 0 immediately and no WE after release.
